// File: rtl/value_stepper_pkg.sv
// Shared types for the value stepper: repeat-FSM states, step direction and a
// small elaboration-time helper.
package value_stepper_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DELAY  = 2'd1,
        S_REPEAT = 2'd2
    } rep_state_t;

    typedef enum logic {
        DIR_UP = 1'b0,
        DIR_DN = 1'b1
    } dir_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/value_stepper_edge_detect.sv
// Tick-gated edge detector; RISING selects which transition of level is reported.
module edge_detect
    import value_stepper_pkg::*;
#(
    parameter bit RISING = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic level,
    output logic pulse
);

    logic prev_r;

    // Level history only advances on ticks so edges are seen at tick resolution.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_r <= 1'b0;
        end else if (ena) begin
            prev_r <= level;
        end else begin
            prev_r <= prev_r;
        end
    end

    assign pulse = ena & (RISING ? (level & ~prev_r) : (prev_r & ~level));

endmodule

// File: rtl/value_stepper.sv
// Bounded up/down value driven by debounced inc/dec levels, with load,
// saturate-or-wrap limits and hold-to-auto-repeat.
module value_stepper
    import value_stepper_pkg::*;
#(
    parameter int MIN_VAL          = 0,
    parameter int MAX_VAL          = 11,
    parameter int DEFAULT_VAL      = 9,
    parameter int WRAP             = 0,
    parameter int CHANGE_ON_RISING = 1,
    parameter int REPEAT_EN        = 1,
    parameter int REPEAT_DELAY     = 8,
    parameter int REPEAT_PERIOD    = 2,
    localparam int VAL_W           = max2(1, $clog2(MAX_VAL + 1))
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             inc,
    input  logic             dec,
    input  logic             load,
    input  logic [VAL_W-1:0] load_val,
    output logic [VAL_W-1:0] value,
    output logic             at_min,
    output logic             at_max,
    output logic             changed
);

    localparam int CNT_W = $clog2(max2(REPEAT_DELAY, REPEAT_PERIOD) + 1);
    localparam logic REP_ON = (REPEAT_EN != 0) && (CHANGE_ON_RISING != 0);
    localparam logic [VAL_W-1:0] MIN_V = VAL_W'(MIN_VAL);
    localparam logic [VAL_W-1:0] MAX_V = VAL_W'(MAX_VAL);
    localparam logic [VAL_W-1:0] DEF_V = VAL_W'(DEFAULT_VAL);

    logic             inc_pulse_s, dec_pulse_s;
    logic             up_s, dn_s, both_s, held_s, abort_s, rep_hit_s, accept_s, step_en_s;
    dir_t             step_dir_s;
    logic [VAL_W-1:0] next_val_s, load_clamped_s;

    logic [VAL_W-1:0] value_r;
    logic             changed_r;
    rep_state_t       state_r;
    dir_t             dir_r;
    logic [CNT_W-1:0] cnt_r;

    // One step in direction d, evaluated one bit wider so +1 at the top cannot overflow.
    function automatic logic [VAL_W-1:0] step_val(input logic [VAL_W-1:0] v, input dir_t d);
        logic [VAL_W:0] ext;
        ext = {1'b0, v};
        if (d == DIR_UP) begin
            if (int'(v) >= MAX_VAL) ext = (WRAP != 0) ? {1'b0, MIN_V} : {1'b0, MAX_V};
            else                    ext = ext + {{VAL_W{1'b0}}, 1'b1};
        end else begin
            if (int'(v) <= MIN_VAL) ext = (WRAP != 0) ? {1'b0, MAX_V} : {1'b0, MIN_V};
            else                    ext = ext - {{VAL_W{1'b0}}, 1'b1};
        end
        return ext[VAL_W-1:0];
    endfunction

    function automatic logic [VAL_W-1:0] clamp_val(input logic [VAL_W-1:0] v);
        if (int'(v) < MIN_VAL)      return MIN_V;
        else if (int'(v) > MAX_VAL) return MAX_V;
        else                        return v;
    endfunction

    edge_detect #(.RISING(CHANGE_ON_RISING != 0)) u_inc_edge (
        .clk(clk), .rst_n(rst_n), .ena(ena), .level(inc), .pulse(inc_pulse_s)
    );

    edge_detect #(.RISING(CHANGE_ON_RISING != 0)) u_dec_edge (
        .clk(clk), .rst_n(rst_n), .ena(ena), .level(dec), .pulse(dec_pulse_s)
    );

    // Decide whether this tick steps, and in which direction (edge or repeat).
    always_comb begin
        up_s    = inc_pulse_s & ~dec_pulse_s;
        dn_s    = dec_pulse_s & ~inc_pulse_s;
        both_s  = inc & dec;
        held_s  = (dir_r == DIR_UP) ? inc : dec;
        abort_s = both_s | ~held_s;
        if (state_r == S_DELAY) begin
            rep_hit_s = (int'(cnt_r) == REPEAT_DELAY);
        end else if (state_r == S_REPEAT) begin
            rep_hit_s = (int'(cnt_r) == REPEAT_PERIOD);
        end else begin
            rep_hit_s = 1'b0;
        end
        // A fresh edge is honoured when idle, or when the held level was released (not both-high).
        accept_s = (up_s | dn_s) & ((state_r == S_IDLE) | (abort_s & ~both_s));
        if (accept_s) begin
            step_en_s  = 1'b1;
            step_dir_s = up_s ? DIR_UP : DIR_DN;
        end else if ((state_r != S_IDLE) && !abort_s) begin
            step_en_s  = rep_hit_s;
            step_dir_s = dir_r;
        end else begin
            step_en_s  = 1'b0;
            step_dir_s = DIR_UP;
        end
        next_val_s     = step_en_s ? step_val(value_r, step_dir_s) : value_r;
        load_clamped_s = clamp_val(load_val);
    end

    // Value, change pulse and repeat FSM; everything except changed freezes between ticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_r   <= DEF_V;
            changed_r <= 1'b0;
            state_r   <= S_IDLE;
            dir_r     <= DIR_UP;
            cnt_r     <= {CNT_W{1'b0}};
        end else if (ena) begin
            if (load) begin
                value_r   <= load_clamped_s;
                changed_r <= (load_clamped_s != value_r);
                state_r   <= S_IDLE;
                cnt_r     <= {CNT_W{1'b0}};
            end else begin
                value_r   <= next_val_s;
                changed_r <= (next_val_s != value_r);
                if (accept_s && REP_ON) begin
                    state_r <= S_DELAY;
                    dir_r   <= step_dir_s;
                    cnt_r   <= CNT_W'(1);
                end else begin
                    case (state_r)
                        S_IDLE: begin
                            cnt_r <= {CNT_W{1'b0}};
                        end
                        S_DELAY, S_REPEAT: begin
                            if (abort_s) begin
                                state_r <= S_IDLE;
                                cnt_r   <= {CNT_W{1'b0}};
                            end else if (rep_hit_s) begin
                                state_r <= S_REPEAT;
                                cnt_r   <= CNT_W'(1);
                            end else begin
                                cnt_r <= cnt_r + CNT_W'(1);
                            end
                        end
                        default: begin
                            state_r <= S_IDLE;
                            cnt_r   <= {CNT_W{1'b0}};
                        end
                    endcase
                end
            end
        end else begin
            changed_r <= 1'b0;
        end
    end

    assign value   = value_r;
    assign changed = changed_r;
    assign at_min  = (value_r == MIN_V);
    assign at_max  = (value_r == MAX_V);

endmodule

// File: tb/tb_value_stepper.sv
// Self-checking bench: four differently parameterised steppers share stimulus and
// are compared against a hold-duration reference model plus directed scenarios.
module tb_value_stepper;

    logic clk = 1'b0, rst_n = 1'b0, ena = 1'b0, inc = 1'b0, dec = 1'b0, load = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic [3:0] v0, v2, v3;
    logic [2:0] v1;
    logic c0, c1, c2, c3, mn0, mn1, mn2, mn3, mx0, mx1, mx2, mx3;

    int checks = 0;
    int errors = 0;

    localparam int P_MIN  [4] = '{0, 2, 0, 0};
    localparam int P_MAX  [4] = '{11, 5, 11, 11};
    localparam int P_DEF  [4] = '{9, 2, 0, 9};
    localparam int P_WRAP [4] = '{0, 1, 0, 0};
    localparam int P_RISE [4] = '{1, 1, 1, 0};
    localparam int P_D    [4] = '{8, 8, 3, 8};
    localparam int P_P    [4] = '{2, 2, 2, 2};

    always #5 clk = ~clk;

    value_stepper #(.MIN_VAL(0), .MAX_VAL(11), .DEFAULT_VAL(9)) dut0 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .inc(inc), .dec(dec), .load(load),
        .load_val(load_val), .value(v0), .at_min(mn0), .at_max(mx0), .changed(c0));
    value_stepper #(.MIN_VAL(2), .MAX_VAL(5), .DEFAULT_VAL(2), .WRAP(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .inc(inc), .dec(dec), .load(load),
        .load_val(load_val[2:0]), .value(v1), .at_min(mn1), .at_max(mx1), .changed(c1));
    value_stepper #(.DEFAULT_VAL(0), .REPEAT_DELAY(3), .REPEAT_PERIOD(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .inc(inc), .dec(dec), .load(load),
        .load_val(load_val), .value(v2), .at_min(mn2), .at_max(mx2), .changed(c2));
    value_stepper #(.CHANGE_ON_RISING(0)) dut3 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .inc(inc), .dec(dec), .load(load),
        .load_val(load_val), .value(v3), .at_min(mn3), .at_max(mx3), .changed(c3));

    logic [3:0] obs_val [4];
    logic       obs_chg [4];
    logic       obs_min [4];
    logic       obs_max [4];
    assign obs_val[0] = v0;  assign obs_val[1] = {1'b0, v1};
    assign obs_val[2] = v2;  assign obs_val[3] = v3;
    assign obs_chg[0] = c0;  assign obs_chg[1] = c1;  assign obs_chg[2] = c2;  assign obs_chg[3] = c3;
    assign obs_min[0] = mn0; assign obs_min[1] = mn1; assign obs_min[2] = mn2; assign obs_min[3] = mn3;
    assign obs_max[0] = mx0; assign obs_max[1] = mx1; assign obs_max[2] = mx2; assign obs_max[3] = mx3;

    // Reference model: a press starts a "run" counting ticks held; steps at 0, D, D+P, D+2P ...
    int m_val [4];
    bit m_pi  [4];
    bit m_pd  [4];
    int m_run [4];
    bit m_up  [4];
    bit m_chg [4];

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_val[i] = P_DEF[i]; m_pi[i] = 1'b0; m_pd[i] = 1'b0;
            m_run[i] = -1; m_up[i] = 1'b1; m_chg[i] = 1'b0;
        end
    endtask

    task automatic model_tick();
        for (int i = 0; i < 4; i++) begin
            if (!ena) begin
                m_chg[i] = 1'b0;
            end else begin
                bit ie, de, up, dn, skip, step, sdir;
                int old, lv;
                ie = P_RISE[i] != 0 ? (inc && !m_pi[i]) : (m_pi[i] && !inc);
                de = P_RISE[i] != 0 ? (dec && !m_pd[i]) : (m_pd[i] && !dec);
                up = ie && !de; dn = de && !ie;
                old = m_val[i]; step = 0; skip = 0; sdir = 1;
                if (load) begin
                    lv = (i == 1) ? int'(load_val) % 8 : int'(load_val);
                    m_val[i] = (lv < P_MIN[i]) ? P_MIN[i] : ((lv > P_MAX[i]) ? P_MAX[i] : lv);
                    m_run[i] = -1;
                end else begin
                    if (m_run[i] >= 0) begin
                        if (inc && dec) begin
                            m_run[i] = -1; skip = 1;
                        end else if (!(m_up[i] ? inc : dec)) begin
                            m_run[i] = -1;
                        end else begin
                            m_run[i]++;
                            if (m_run[i] == P_D[i] || (m_run[i] > P_D[i] && (m_run[i] - P_D[i]) % P_P[i] == 0)) begin
                                step = 1; sdir = m_up[i];
                            end
                        end
                    end
                    if (m_run[i] < 0 && !skip && (up || dn)) begin
                        step = 1; sdir = up;
                        if (P_RISE[i] != 0) begin m_run[i] = 0; m_up[i] = up; end
                    end
                    if (step && sdir)
                        m_val[i] = (m_val[i] == P_MAX[i]) ? (P_WRAP[i] != 0 ? P_MIN[i] : P_MAX[i]) : m_val[i] + 1;
                    else if (step)
                        m_val[i] = (m_val[i] == P_MIN[i]) ? (P_WRAP[i] != 0 ? P_MAX[i] : P_MIN[i]) : m_val[i] - 1;
                end
                m_chg[i] = (m_val[i] != old);
                m_pi[i] = inc; m_pd[i] = dec;
            end
        end
    endtask

    task automatic tick();
        model_tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        inc = 1'b0; dec = 1'b0; load = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ena = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        load = 1'b1; load_val = 4'd4;
        tick();
        load = 1'b0;
        checks++;
        if (v0 !== 4'd4) begin errors++; $display("FAIL reset_preload: value=%0d expected 4", v0); end
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (v0 !== 4'd9 || c0 !== 1'b0 || mn0 !== 1'b0 || mx0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: value=%0d changed=%b at_min=%b at_max=%b expected 9 0 0 0", v0, c0, mn0, mx0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_saturate();
        int exp_v [3] = '{10, 11, 11};
        bit exp_c [3] = '{1'b1, 1'b1, 1'b0};
        bit exp_m [3] = '{1'b0, 1'b1, 1'b1};
        do_reset();
        for (int k = 0; k < 3; k++) begin
            inc = 1'b1; tick();
            checks++;
            if (v0 !== 4'(exp_v[k]) || c0 !== exp_c[k] || mx0 !== exp_m[k]) begin
                errors++;
                $display("FAIL saturate_%0d: value=%0d changed=%b at_max=%b expected %0d %b %b",
                         k, v0, c0, mx0, exp_v[k], exp_c[k], exp_m[k]);
            end
            inc = 1'b0; tick();
            checks++;
            if (c0 !== 1'b0) begin errors++; $display("FAIL saturate_gap_%0d: changed=%b expected 0", k, c0); end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        dec = 1'b1; tick();
        checks++;
        if (v1 !== 3'd5 || c1 !== 1'b1 || mx1 !== 1'b1) begin
            errors++; $display("FAIL wrap_down: value=%0d changed=%b at_max=%b expected 5 1 1", v1, c1, mx1);
        end
        dec = 1'b0; tick();
        inc = 1'b1; tick();
        checks++;
        if (v1 !== 3'd2 || c1 !== 1'b1 || mn1 !== 1'b1) begin
            errors++; $display("FAIL wrap_up: value=%0d changed=%b at_min=%b expected 2 1 1", v1, c1, mn1);
        end
        inc = 1'b0; tick();
    endtask

    task automatic test_simultaneous();
        do_reset();
        inc = 1'b1; dec = 1'b1; tick();
        checks++;
        if (v0 !== 4'd9 || c0 !== 1'b0) begin
            errors++; $display("FAIL simul_edge: value=%0d changed=%b expected 9 0", v0, c0);
        end
        repeat (12) tick();
        checks++;
        if (v0 !== 4'd9 || c0 !== 1'b0) begin
            errors++; $display("FAIL simul_hold: value=%0d changed=%b expected 9 0", v0, c0);
        end
        inc = 1'b0; dec = 1'b0; tick();
    endtask

    task automatic test_repeat();
        int exp_v [10] = '{1, 1, 1, 2, 2, 3, 3, 4, 4, 5};
        bit exp_c [10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        do_reset();
        inc = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if (v2 !== 4'(exp_v[k]) || c2 !== exp_c[k]) begin
                errors++;
                $display("FAIL repeat_tick%0d: value=%0d changed=%b expected %0d %b", k, v2, c2, exp_v[k], exp_c[k]);
            end
        end
        inc = 1'b0;
        repeat (3) tick();
        checks++;
        if (v2 !== 4'd5 || c2 !== 1'b0) begin
            errors++; $display("FAIL repeat_release: value=%0d changed=%b expected 5 0", v2, c2);
        end
    endtask

    task automatic test_load();
        do_reset();
        inc = 1'b1;
        repeat (5) tick();
        load = 1'b1; load_val = 4'd15; tick();
        checks++;
        if (v2 !== 4'd11 || mx2 !== 1'b1 || v0 !== 4'd11) begin
            errors++; $display("FAIL load_clamp: value=%0d at_max=%b value0=%0d expected 11 1 11", v2, mx2, v0);
        end
        load_val = 4'd1; tick();
        checks++;
        if (v2 !== 4'd1 || c2 !== 1'b1) begin
            errors++; $display("FAIL load_value: value=%0d changed=%b expected 1 1", v2, c2);
        end
        load = 1'b0;
        repeat (10) tick();
        checks++;
        if (v2 !== 4'd1) begin errors++; $display("FAIL load_abort: value=%0d expected 1", v2); end
        inc = 1'b0; tick();
    endtask

    task automatic test_falling();
        do_reset();
        inc = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (v3 !== 4'd9) begin errors++; $display("FAIL falling_hold%0d: value=%0d expected 9", k, v3); end
        end
        inc = 1'b0; tick();
        checks++;
        if (v3 !== 4'd10 || c3 !== 1'b1) begin
            errors++; $display("FAIL falling_release: value=%0d changed=%b expected 10 1", v3, c3);
        end
        tick();
        checks++;
        if (v3 !== 4'd10 || c3 !== 1'b0) begin
            errors++; $display("FAIL falling_after: value=%0d changed=%b expected 10 0", v3, c3);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            if (n % 700 == 699) do_reset();
            ena  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 11) == 0) inc = ~inc;
            if ($urandom_range(0, 11) == 0) dec = ~dec;
            load     = ($urandom_range(0, 40) == 0);
            load_val = 4'($urandom_range(0, 15));
            tick();
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (obs_val[i] !== 4'(m_val[i]) || obs_chg[i] !== m_chg[i] ||
                    obs_min[i] !== (m_val[i] == P_MIN[i]) || obs_max[i] !== (m_val[i] == P_MAX[i])) begin
                    errors++;
                    $display("FAIL random_dut%0d_n%0d: value=%0d changed=%b min=%b max=%b expected %0d %b %b %b",
                             i, n, obs_val[i], obs_chg[i], obs_min[i], obs_max[i], m_val[i], m_chg[i],
                             m_val[i] == P_MIN[i], m_val[i] == P_MAX[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_saturate();
        test_wrap();
        test_simultaneous();
        test_repeat();
        test_load();
        test_falling();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
